conv3x3_rgb_engine: RTL and testbench
=====================================

// Module: conv3x3_rgb_engine
// PURPOSE
//  Downstream consumer of cnn_top's 3x3 window stage. Takes the nine 24-bit RGB pixels of
//  one window (oOut0..oOut8 / oValid), convolves each 8-bit channel with a programmable
//  signed 3x3 kernel, clamps the results, and buffers them in a small output FIFO.
//  Drives oBusy back into cnn_top's iBusy so the window stage stalls before the FIFO fills.
// PARAMETERS
//  FIFO_DEPTH   8   output FIFO entries (power of 2, >= 4)
//  SHIFT        4   arithmetic right shift applied to each channel sum (kernel scale 2^SHIFT)
//  BUSY_MARGIN  2   free-slot margin reserved for upstream stall reaction
// PORTS
//  iClk        in   1    clock
//  iRst        in   1    asynchronous, active-high reset
//  iWin0..8    in   24   window pixels, row-major (0 = top-left, 4 = centre); [23:16]R [15:8]G [7:0]B
//  iValid      in   1    window valid, one window per cycle
//  oBusy       out  1    stall request to the upstream stage (connects to cnn_top iBusy)
//  iCoefWe     in   1    shadow-kernel write strobe
//  iCoefAddr   in   4    coefficient index 0..8; writes to 9..15 are ignored
//  iCoefData   in   8    signed coefficient
//  iCoefCommit in   1    pulse: request shadow-to-active kernel swap
//  oPixel      out  24   FIFO head, same channel packing as input
//  oValid      out  1    FIFO not empty
//  iReady      in   1    consumer accepts oPixel when oValid & iReady
//  oOverflow   out  1    sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty, pipeline valids 0, FSM = RUN. Active and shadow
//   kernels = identity (coef4 = 2^SHIFT, all others 0).
//  Pipeline: 3 stages, each stage tagged with a valid bit.
//   S1: 27 products, unsigned 8b x signed 8b -> signed 17b.
//   S2: per-channel row sums, signed 19b.
//   S3: per-channel total, signed 21b; >>> SHIFT; clamp to 0..255.
//  Latency: iValid in cycle N -> result written at the edge ending cycle N+3 -> oValid
//   high in cycle N+4 when the FIFO was empty. FIFO is show-ahead.
//  FIFO: a simultaneous write and read on a full FIFO succeeds. A write on a full FIFO
//   without a read drops the result and sets oOverflow; only iRst clears oOverflow.
//   Output order equals input order.
//  oBusy (combinational) = (fifo_count + pipe_valids) >= FIFO_DEPTH - BUSY_MARGIN,
//   or FSM != RUN. iValid is still accepted while oBusy is high; nothing is rejected at input.
//  Kernel FSM:
//   RUN   : iCoefWe writes the shadow bank at any time. iCoefCommit -> DRAIN.
//   DRAIN : oBusy = 1. iValid is still accepted and processed with the old kernel.
//           When all pipe valids are 0 and iValid is 0 -> SWAP.
//   SWAP  : one cycle; copy shadow to active -> RUN.
//   iCoefCommit outside RUN is ignored. Windows already in flight always use the kernel
//   that was active when they entered S1.
//  Reset mid-operation: FIFO contents, in-flight data and kernels are all discarded;
//   the block restarts in the reset state.
// STRUCTURE
//  Shared package conv_pkg: PIX_W = 24, CH_W = 8, COEF_W = 8, SUM_W = 21, FSM state
//   encodings (RUN, DRAIN, SWAP), and function clamp_u8(signed SUM_W).
//  One sub-module: conv_out_fifo (synchronous show-ahead FIFO with count output).
//  The MAC pipeline, kernel banks and FSM stay in this module.
// TESTING
//  1 Identity kernel; iWin4 = 0x102030, other windows random, iValid at cycle N
//    -> oPixel = 0x102030 with oValid in cycle N+4.
//  2 All coefs = 1; all nine pixels = 0xFFFFFF -> (9*255) >> 4 = 143 -> 0x8F8F8F.
//  3 coef4 = -16, others 0, pixels 0x101010 -> 0x000000 (negative clamp).
//    coef4 = 127, pixels 0xFFFFFF -> 0xFFFFFF (positive clamp).
//  4 iReady = 0; 12 back-to-back windows, upstream model stops one cycle after oBusy
//    -> oBusy rises when count + inflight = 6; oOverflow stays 0; after iReady = 1 all
//    results drain in order. Without the upstream stop -> oOverflow = 1.
//  5 Stream identity windows; write an all-ones shadow kernel, pulse iCoefCommit mid-stream
//    -> oBusy is held through DRAIN and SWAP; windows issued before the commit give identity
//    results, windows issued after SWAP give box-sum results; no window is lost.
//  6 Assert iRst with 5 entries in the FIFO and a commit pending -> oValid, oBusy and
//    oOverflow are 0 immediately; test 1 passes after release, proving identity is restored.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, kernel FSM encoding and the output clamp used by the 3x3 RGB convolution engine.
package conv_pkg;
  localparam int PIX_W  = 24;
  localparam int CH_W   = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = 17;
  localparam int ROW_W  = 19;
  localparam int SUM_W  = 21;
  localparam int NTAP   = 9;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } fsm_state_t;

  // Negative sums saturate to 0, anything above 255 saturates to 255.
  function automatic logic [CH_W-1:0] clamp_u8(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])
      return '0;
    else if (|v[SUM_W-2:CH_W])
      return {CH_W{1'b1}};
    else
      return v[CH_W-1:0];
  endfunction
endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever valid is high.
module conv_out_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  output logic                     drop,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_rd;
  logic          do_wr;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && valid;
  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign do_wr   = wr_en && (!full || do_rd);
  assign drop    = wr_en && full && !rd_en;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_rd)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/conv3x3_rgb_engine.sv
// Per-channel signed 3x3 convolution of one RGB window per cycle, with a double-buffered
// kernel swapped only after the pipeline drains, and a show-ahead result FIFO.
module conv3x3_rgb_engine
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SHIFT       = 4,
  parameter int BUSY_MARGIN = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [PIX_W-1:0]  iWin0,
  input  logic [PIX_W-1:0]  iWin1,
  input  logic [PIX_W-1:0]  iWin2,
  input  logic [PIX_W-1:0]  iWin3,
  input  logic [PIX_W-1:0]  iWin4,
  input  logic [PIX_W-1:0]  iWin5,
  input  logic [PIX_W-1:0]  iWin6,
  input  logic [PIX_W-1:0]  iWin7,
  input  logic [PIX_W-1:0]  iWin8,
  input  logic              iValid,
  output logic              oBusy,
  input  logic              iCoefWe,
  input  logic [3:0]        iCoefAddr,
  input  logic [COEF_W-1:0] iCoefData,
  input  logic              iCoefCommit,
  output logic [PIX_W-1:0]  oPixel,
  output logic              oValid,
  input  logic              iReady,
  output logic              oOverflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam logic signed [COEF_W-1:0] UNIT_COEF = COEF_W'(1 << SHIFT);

  logic [PIX_W-1:0]         win [NTAP];
  logic signed [COEF_W-1:0] active [NTAP];
  logic signed [COEF_W-1:0] shadow [NTAP];
  logic signed [PROD_W-1:0] prod [3][NTAP];
  logic signed [ROW_W-1:0]  row_sum [3][3];
  logic signed [SUM_W-1:0]  total [3];
  logic signed [SUM_W-1:0]  scaled [3];
  logic [PIX_W-1:0]         s3_pix;
  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s3_valid;
  logic [1:0]               pipe_cnt;
  logic [AW:0]              fifo_count;
  logic                     fifo_drop;
  fsm_state_t               state;

  assign win[0] = iWin0;
  assign win[1] = iWin1;
  assign win[2] = iWin2;
  assign win[3] = iWin3;
  assign win[4] = iWin4;
  assign win[5] = iWin5;
  assign win[6] = iWin6;
  assign win[7] = iWin7;
  assign win[8] = iWin8;

  // Channel c = 0 is red (bits 23:16); pixels are zero-extended so they multiply as unsigned.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1_valid <= 1'b0;
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < NTAP; k++)
          prod[c][k] <= '0;
    end else begin
      s1_valid <= iValid;
      if (iValid)
        for (int c = 0; c < 3; c++)
          for (int k = 0; k < NTAP; k++)
            prod[c][k] <= PROD_W'($signed({1'b0, win[k][CH_W*(2-c) +: CH_W]})) *
                          PROD_W'(active[k]);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s2_valid <= 1'b0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          row_sum[c][r] <= '0;
    end else begin
      s2_valid <= s1_valid;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          row_sum[c][r] <= ROW_W'(prod[c][3*r]) + ROW_W'(prod[c][3*r+1]) +
                           ROW_W'(prod[c][3*r+2]);
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      total[c]  = SUM_W'(row_sum[c][0]) + SUM_W'(row_sum[c][1]) + SUM_W'(row_sum[c][2]);
      scaled[c] = total[c] >>> SHIFT;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s3_valid <= 1'b0;
      s3_pix   <= '0;
    end else begin
      s3_valid <= s2_valid;
      for (int c = 0; c < 3; c++)
        s3_pix[CH_W*(2-c) +: CH_W] <= clamp_u8(scaled[c]);
    end
  end

  conv_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk     (iClk),
    .rst     (iRst),
    .wr_en   (s3_valid),
    .wr_data (s3_pix),
    .drop    (fifo_drop),
    .rd_en   (iReady),
    .rd_data (oPixel),
    .valid   (oValid),
    .count   (fifo_count)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)
      oOverflow <= 1'b0;
    else if (fifo_drop)
      oOverflow <= 1'b1;
  end

  // Results already committed to the pipeline count against free FIFO slots.
  assign pipe_cnt = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, s3_valid};
  assign oBusy    = ((CW'(fifo_count) + CW'(pipe_cnt)) >= CW'(FIFO_DEPTH - BUSY_MARGIN)) ||
                    (state != RUN);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= RUN;
      for (int k = 0; k < NTAP; k++) begin
        active[k] <= (k == 4) ? UNIT_COEF : '0;
        shadow[k] <= (k == 4) ? UNIT_COEF : '0;
      end
    end else begin
      if (iCoefWe && (iCoefAddr < 4'd9))
        shadow[iCoefAddr] <= iCoefData;
      case (state)
        RUN: begin
          if (iCoefCommit)
            state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid && !s3_valid && !iValid)
            state <= SWAP;
        end
        SWAP: begin
          for (int k = 0; k < NTAP; k++)
            active[k] <= shadow[k];
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_rgb_engine.sv
// Directed bench for conv3x3_rgb_engine: latency, kernel math and clamping, FIFO back-pressure,
// overflow, mid-stream kernel swap and asynchronous reset.
module tb_conv3x3_rgb_engine;
  logic        iClk = 1'b0;
  logic        iRst;
  logic [23:0] iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8;
  logic        iValid;
  logic        oBusy;
  logic        iCoefWe;
  logic [3:0]  iCoefAddr;
  logic [7:0]  iCoefData;
  logic        iCoefCommit;
  logic [23:0] oPixel;
  logic        oValid;
  logic        iReady;
  logic        oOverflow;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q[$];

  conv3x3_rgb_engine dut (
    .iClk(iClk), .iRst(iRst),
    .iWin0(iWin0), .iWin1(iWin1), .iWin2(iWin2), .iWin3(iWin3), .iWin4(iWin4),
    .iWin5(iWin5), .iWin6(iWin6), .iWin7(iWin7), .iWin8(iWin8),
    .iValid(iValid), .oBusy(oBusy),
    .iCoefWe(iCoefWe), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData),
    .iCoefCommit(iCoefCommit),
    .oPixel(oPixel), .oValid(oValid), .iReady(iReady), .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(negedge iClk);
  endtask

  task automatic set_all(input logic [23:0] p);
    {iWin0, iWin1, iWin2, iWin3, iWin4, iWin5, iWin6, iWin7, iWin8} = {9{p}};
  endtask

  task automatic set_centre_rand(input logic [23:0] c);
    iWin0 = 24'($urandom); iWin1 = 24'($urandom); iWin2 = 24'($urandom);
    iWin3 = 24'($urandom); iWin4 = c;             iWin5 = 24'($urandom);
    iWin6 = 24'($urandom); iWin7 = 24'($urandom); iWin8 = 24'($urandom);
  endtask

  function automatic logic [23:0] pattern(input int i);
    logic [7:0] r, g, b;
    r = 8'(20 + i * 9);
    g = 8'(200 - i * 7);
    b = 8'(90 + i * 5);
    return {r, g, b};
  endfunction

  // Expected result of the all-ones kernel on a window of nine identical pixels.
  function automatic logic [23:0] box9(input logic [23:0] p);
    logic [23:0] res;
    for (int c = 0; c < 3; c++) begin
      int v;
      v = 9 * int'(p[8*c +: 8]);
      res[8*c +: 8] = 8'(v >> 4);
    end
    return res;
  endfunction

  task automatic reset_dut;
    iRst = 1'b1; iValid = 1'b0; iCoefWe = 1'b0; iCoefCommit = 1'b0;
    iCoefAddr = '0; iCoefData = '0; iReady = 1'b1;
    set_all(24'h0);
    tick; tick;
    iRst = 1'b0;
    tick;
  endtask

  task automatic write_shadow(input logic [71:0] k);
    for (int i = 0; i < 9; i++) begin
      iCoefWe = 1'b1; iCoefAddr = 4'(i); iCoefData = k[8*i +: 8];
      tick;
    end
    // Out-of-range addresses must not land on any tap.
    iCoefAddr = 4'd9;  iCoefData = 8'h7F; tick;
    iCoefAddr = 4'd12; iCoefData = 8'h7F; tick;
    iCoefWe = 1'b0;
  endtask

  task automatic load_kernel(input string tag, input logic [71:0] k);
    write_shadow(k);
    iCoefCommit = 1'b1;
    tick;
    iCoefCommit = 1'b0;
    for (int i = 0; i < 20 && oBusy; i++) tick;
    chk({tag, "_swap_done"}, 32'(oBusy), 32'd0);
  endtask

  task automatic one_window(input string tag, input logic [23:0] pix, input logic [23:0] expv);
    set_all(pix);
    iValid = 1'b1;
    tick;
    iValid = 1'b0;
    for (int i = 0; i < 8 && !oValid; i++) tick;
    chk({tag, "_valid"}, 32'(oValid), 32'd1);
    chk({tag, "_pix"}, 32'(oPixel), 32'(expv));
    tick;
  endtask

  task automatic test_identity(input string tag);
    iReady = 1'b1;
    set_centre_rand(24'h102030);
    iValid = 1'b1;
    tick;
    iValid = 1'b0;
    chk({tag, "_n1_valid"}, 32'(oValid), 32'd0);
    tick;
    chk({tag, "_n2_valid"}, 32'(oValid), 32'd0);
    tick;
    chk({tag, "_n3_valid"}, 32'(oValid), 32'd0);
    tick;
    chk({tag, "_n4_valid"}, 32'(oValid), 32'd1);
    chk({tag, "_n4_pix"}, 32'(oPixel), 32'h102030);
    tick;
    chk({tag, "_popped"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    int sent, recv, busy_run;
    bit prev_busy, busy, first_busy, new_k, committed, done;
    logic [23:0] p;
    logic [71:0] k;

    iRst = 1'b1;
    reset_dut;
    chk("reset_valid", 32'(oValid), 32'd0);
    chk("reset_busy", 32'(oBusy), 32'd0);
    chk("reset_overflow", 32'(oOverflow), 32'd0);
    chk("reset_pixel", 32'(oPixel), 32'd0);

    // Identity kernel and exact latency
    test_identity("t1");

    // All-ones kernel: (9*255)>>4 = 143
    load_kernel("t2", {9{8'h01}});
    one_window("t2_box", 24'hFFFFFF, 24'h8F8F8F);

    // Clamping on a single centre tap
    k = '0; k[8*4 +: 8] = 8'hF0;
    load_kernel("t3neg", k);
    one_window("t3_negclamp", 24'h101010, 24'h000000);
    k = '0; k[8*4 +: 8] = 8'h7F;
    load_kernel("t3pos", k);
    one_window("t3_posclamp", 24'hFFFFFF, 24'hFFFFFF);
    one_window("t3_scale", 24'h010203, 24'h070F17);

    // Back-pressure with an upstream that reacts one cycle late
    reset_dut;
    iReady = 1'b0; sent = 0; prev_busy = 1'b0; first_busy = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (oBusy && !first_busy) begin
        first_busy = 1'b1;
        chk("t4_busy_rise_count", 32'(sent), 32'd6);
      end
      if (!prev_busy && sent < 12) begin
        p = 24'h0A0B0C + 24'(sent) * 24'h010203;
        set_centre_rand(p);
        exp_q.push_back(p);
        sent++;
        iValid = 1'b1;
      end else begin
        iValid = 1'b0;
      end
      prev_busy = oBusy;
      tick;
    end
    chk("t4_busy_seen", 32'(first_busy), 32'd1);
    chk("t4_sent_before_stall", 32'(sent), 32'd7);
    chk("t4_no_overflow_hold", 32'(oOverflow), 32'd0);
    iReady = 1'b1; recv = 0; done = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (oValid) begin
        if (exp_q.size() == 0) begin
          chk("t4_unexpected_out", 32'(oPixel), 32'hFFFFFFFF);
        end else begin
          chk("t4_order", 32'(oPixel), 32'(exp_q.pop_front()));
          recv++;
        end
      end
      if (!prev_busy && sent < 12) begin
        p = 24'h0A0B0C + 24'(sent) * 24'h010203;
        set_centre_rand(p);
        exp_q.push_back(p);
        sent++;
        iValid = 1'b1;
      end else begin
        iValid = 1'b0;
      end
      prev_busy = oBusy;
      done = (sent == 12) && (exp_q.size() == 0);
      tick;
    end
    iValid = 1'b0;
    chk("t4_received", 32'(recv), 32'd12);
    chk("t4_no_overflow", 32'(oOverflow), 32'd0);

    // Ignoring busy: four results are dropped and the flag sticks
    iReady = 1'b0;
    for (int i = 0; i < 12; i++) begin
      p = 24'h300000 + 24'(i) * 24'h000111;
      set_centre_rand(p);
      exp_q.push_back(p);
      iValid = 1'b1;
      tick;
    end
    iValid = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    chk("t4b_overflow", 32'(oOverflow), 32'd1);
    chk("t4b_busy_full", 32'(oBusy), 32'd1);
    iReady = 1'b1; recv = 0;
    for (int cyc = 0; cyc < 20 && recv < 8; cyc++) begin
      if (oValid) begin
        chk("t4b_order", 32'(oPixel), 32'(exp_q.pop_front()));
        recv++;
      end
      tick;
    end
    chk("t4b_kept", 32'(recv), 32'd8);
    tick;
    chk("t4b_empty", 32'(oValid), 32'd0);
    chk("t4b_sticky", 32'(oOverflow), 32'd1);
    exp_q.delete();

    // Kernel swap in the middle of a stream
    reset_dut;
    write_shadow({9{8'h01}});
    iReady = 1'b1; sent = 0; recv = 0; prev_busy = 1'b0; new_k = 1'b0;
    committed = 1'b0; busy_run = 0; done = 1'b0;
    for (int cyc = 0; cyc < 150 && !done; cyc++) begin
      if (oValid) begin
        if (exp_q.size() == 0) begin
          chk("t5_unexpected_out", 32'(oPixel), 32'hFFFFFFFF);
        end else begin
          chk("t5_result", 32'(oPixel), 32'(exp_q.pop_front()));
          recv++;
        end
      end
      busy = oBusy;
      if (committed && !new_k) begin
        if (busy) begin
          busy_run++;
        end else if (prev_busy) begin
          new_k = 1'b1;
          chk("t5_busy_run", 32'(busy_run), 32'd6);
        end
      end
      if (!committed && sent == 10) begin
        iCoefCommit = 1'b1;
        committed = 1'b1;
      end else begin
        iCoefCommit = 1'b0;
      end
      if (!prev_busy && sent < 20) begin
        p = pattern(sent);
        set_all(p);
        exp_q.push_back(new_k ? box9(p) : p);
        sent++;
        iValid = 1'b1;
      end else begin
        iValid = 1'b0;
      end
      prev_busy = busy;
      done = (sent == 20) && (exp_q.size() == 0);
      tick;
    end
    iValid = 1'b0; iCoefCommit = 1'b0;
    chk("t5_swapped", 32'(new_k), 32'd1);
    chk("t5_received", 32'(recv), 32'd20);

    // Reset with a loaded FIFO and a commit in progress
    iReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_centre_rand(24'h050505 * 24'(i + 1));
      iValid = 1'b1;
      tick;
    end
    iValid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chk("t6_loaded", 32'(oValid), 32'd1);
    write_shadow({9{8'h02}});
    iCoefCommit = 1'b1;
    tick;
    iCoefCommit = 1'b0;
    chk("t6_draining", 32'(oBusy), 32'd1);
    iRst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(oValid), 32'd0);
    chk("t6_rst_busy", 32'(oBusy), 32'd0);
    chk("t6_rst_overflow", 32'(oOverflow), 32'd0);
    tick;
    iRst = 1'b0;
    tick;
    test_identity("t6_t1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
